// File: rtl/operand_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module      : operand_sel_pipe
// Description : NUM_IN-way operand select with registered output, valid/ready
//               handshake, 2-entry skid buffer and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_sel_pipe #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [NUM_IN*WIDTH-1:0] data_in_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [SEL_W-1:0]        out_sel_o,
    output logic                    sel_err_o
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } entry_t;

    logic [WIDTH-1:0] in_words [NUM_IN];

    entry_t new_entry;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;

    logic   accept;
    logic   release_out;

    generate
        for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
            assign in_words[g] = data_in_i[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Out-of-range selects match no input and fall through as zero data with err set.
    always_comb begin
        new_entry      = '0;
        new_entry.sel  = sel_i;
        new_entry.err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_i == SEL_W'(k)) begin
                new_entry.data = in_words[k];
                new_entry.err  = 1'b0;
            end
        end
    end

    assign accept      = in_valid_i && !skid_valid_q && !flush_i;
    assign release_out = main_valid_q && out_ready_i;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            main_d       = '0;
            main_valid_d = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || release_out) begin
            // Main slot frees up: the skid entry is older than anything offered now.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_q.data;
    assign out_sel_o   = main_q.sel;
    assign sel_err_o   = main_q.err;

endmodule
`default_nettype wire
